// File: rtl/alu_cmd_issuer_if.sv
// Command, ALU and response signal bundle for alu_cmd_issuer.
// slave is the issuer's view; master is the view of the block that feeds and drains it.
interface alu_cmd_issuer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [2:0] cmd_op;
    logic [3:0] cmd_tag;

    logic       alu_start;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_mode;
    logic [7:0] alu_c;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [3:0] rsp_tag;
    logic       rsp_err;

    logic       busy;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, rsp_ready, alu_c,
        input  cmd_ready, alu_start, alu_a, alu_b, alu_mode,
        input  rsp_valid, rsp_data, rsp_tag, rsp_err, busy
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, rsp_ready, alu_c,
        output cmd_ready, alu_start, alu_a, alu_b, alu_mode,
        output rsp_valid, rsp_data, rsp_tag, rsp_err, busy
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Queues ALU commands and issues them one at a time to an external ALU.
// Results come back in acceptance order; illegal ops and zero divisors are answered with an error.
module alu_cmd_issuer #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned RESULT_LATENCY = 1
) (
    input  logic            clock,
    input  logic            reset_n,
    alu_cmd_issuer_if.slave bus
);
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned LatW = (RESULT_LATENCY > 1) ? $clog2(RESULT_LATENCY) : 1;

    localparam logic [2:0] OpDiv     = 3'd3;
    localparam logic [2:0] OpMod     = 3'd4;
    localparam logic [2:0] OpLastLegal = 3'd4;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [3:0] tag;
    } cmd_t;

    typedef enum logic [1:0] {StIdle, StIssue, StCapture, StRespond} state_e;

    state_e            state_q, state_d;
    logic [LatW-1:0]   lat_q, lat_d;
    cmd_t              fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q;
    cmd_t              work_q;
    logic [7:0]        rsp_data_q;
    logic              rsp_err_q;

    cmd_t              cmd_in;
    cmd_t              head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              cmd_ready;
    logic              push;
    logic              pop;
    logic              head_err;
    logic              alu_start;
    logic              rsp_valid;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign cmd_in     = '{a: bus.cmd_a, b: bus.cmd_b, op: bus.cmd_op, tag: bus.cmd_tag};
    assign head       = fifo_mem[rd_ptr_q];
    assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    // Held low for the whole reset so nothing is accepted while state is being cleared.
    assign cmd_ready  = reset_n && !fifo_full;
    assign push       = bus.cmd_valid && cmd_ready;
    assign pop        = (state_q == StIdle) && !fifo_empty;
    assign head_err   = (head.op > OpLastLegal) ||
                        (((head.op == OpDiv) || (head.op == OpMod)) && (head.b == 8'd0));

    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        alu_start = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    state_d = head_err ? StRespond : StIssue;
                    lat_d   = '0;
                end
            end
            StIssue: begin
                alu_start = (lat_q == '0);
                if (lat_q == LatW'(RESULT_LATENCY - 1)) begin
                    state_d = StCapture;
                end else begin
                    lat_d = lat_q + LatW'(1);
                end
            end
            StCapture: begin
                state_d = StRespond;
            end
            StRespond: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            lat_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            work_q     <= '0;
            rsp_data_q <= 8'd0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q   <= ptr_inc(rd_ptr_q);
                work_q     <= head;
                rsp_data_q <= 8'd0;
                rsp_err_q  <= head_err;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
            // The ALU result register has no reset value, so alu_c is only looked at here.
            if (state_q == StCapture) begin
                rsp_data_q <= bus.alu_c;
                rsp_err_q  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= cmd_in;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.alu_start = alu_start;
    assign bus.alu_a     = work_q.a;
    assign bus.alu_b     = work_q.b;
    assign bus.alu_mode  = work_q.op;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_tag   = work_q.tag;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = (state_q != StIdle) || !fifo_empty;
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Randomized bench for alu_cmd_issuer: a queue-based response model plus directed
// latency, error, capacity, reset and back-pressure scenarios.
module tb_alu_cmd_issuer;
    localparam int unsigned FD = 4;
    localparam int unsigned RL = 1;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [3:0] tag;
    } cmd_s;

    logic clock;
    logic reset_n;
    alu_cmd_issuer_if bus ();

    alu_cmd_issuer #(
        .FIFO_DEPTH    (FD),
        .RESULT_LATENCY(RL)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_starts = 0;
    int n_rsp    = 0;
    int n_unexp  = 0;

    cmd_s exp_q[$];
    int   head_starts = 0;
    logic hold_v = 1'b0;
    logic [7:0] hold_data;
    logic [3:0] hold_tag;
    logic hold_err;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Expected response {err, data} straight from the opcode rules.
    function automatic logic [8:0] ref_rsp(input cmd_s c);
        int ua;
        int ub;
        int r;
        ua = int'(c.a);
        ub = int'(c.b);
        case (c.op)
            3'd0: r = ua + ub;
            3'd1: r = ua - ub;
            3'd2: r = ua * ub;
            3'd3: begin
                if (ub == 0) return 9'h100;
                r = ua / ub;
            end
            3'd4: begin
                if (ub == 0) return 9'h100;
                r = ua % ub;
            end
            default: return 9'h100;
        endcase
        return {1'b0, r[7:0]};
    endfunction

    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] m);
        case (m)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a * b;
            3'd3: return (b == 0) ? 8'hff : a / b;
            3'd4: return (b == 0) ? 8'hff : a % b;
            default: return 8'hff;
        endcase
    endfunction

    // ALU model: result valid only RL cycles after start, junk otherwise.
    logic       alu_vld [RL];
    logic [7:0] alu_res [RL];
    logic [7:0] alu_junk;
    always @(posedge clock) begin
        alu_vld[0] <= bus.alu_start;
        alu_res[0] <= alu_fn(bus.alu_a, bus.alu_b, bus.alu_mode);
        for (int k = 1; k < int'(RL); k++) begin
            alu_vld[k] <= alu_vld[k-1];
            alu_res[k] <= alu_res[k-1];
        end
        alu_junk <= 8'($urandom);
    end
    assign bus.alu_c = alu_vld[RL-1] ? alu_res[RL-1] : alu_junk;

    // Monitor and scoreboard; inputs only change just after posedge.
    initial begin
        logic [8:0] r;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                exp_q.delete();
                head_starts = 0;
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    check_eq("hold_valid", bus.rsp_valid, 1);
                    check_eq("hold_data", bus.rsp_data, hold_data);
                    check_eq("hold_tag", bus.rsp_tag, hold_tag);
                    check_eq("hold_err", bus.rsp_err, hold_err);
                end
                if (bus.alu_start) begin
                    n_starts++;
                    head_starts++;
                    if (exp_q.size() == 0) begin
                        n_unexp++;
                        check_eq("start_unexpected", bus.alu_start, 0);
                    end else begin
                        check_eq("alu_a", bus.alu_a, exp_q[0].a);
                        check_eq("alu_b", bus.alu_b, exp_q[0].b);
                        check_eq("alu_mode", bus.alu_mode, exp_q[0].op);
                    end
                end
                hold_v = 1'b0;
                if (bus.rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        n_unexp++;
                        check_eq("rsp_unexpected", bus.rsp_valid, 0);
                    end else begin
                        r = ref_rsp(exp_q[0]);
                        if (bus.rsp_ready) begin
                            check_eq("rsp_data", bus.rsp_data, r[7:0]);
                            check_eq("rsp_tag", bus.rsp_tag, exp_q[0].tag);
                            check_eq("rsp_err", bus.rsp_err, r[8]);
                            check_eq("alu_starts", head_starts, r[8] ? 0 : 1);
                            void'(exp_q.pop_front());
                            head_starts = 0;
                            n_rsp++;
                        end else begin
                            hold_v    = 1'b1;
                            hold_data = bus.rsp_data;
                            hold_tag  = bus.rsp_tag;
                            hold_err  = bus.rsp_err;
                        end
                    end
                end
                if (bus.cmd_valid && bus.cmd_ready) begin
                    exp_q.push_back('{a: bus.cmd_a, b: bus.cmd_b, op: bus.cmd_op, tag: bus.cmd_tag});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                            input logic [3:0] tag);
        logic ok;
        ok = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_a = a;
        bus.cmd_b = b;
        bus.cmd_op = op;
        bus.cmd_tag = tag;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clock);
            ok = bus.cmd_ready;
            tick();
        end
        bus.cmd_valid = 1'b0;
        check_eq("send_accept", ok, 1);
    endtask

    // Returns at the negedge of the first cycle with rsp_valid; lat counts cycles waited.
    task automatic wait_rsp(output int lat);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            lat++;
            if (bus.rsp_valid) break;
        end
        check_eq("rsp_seen", bus.rsp_valid, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (!bus.busy && !bus.rsp_valid && exp_q.size() == 0) break;
        end
        check_eq("drain_busy", bus.busy, 0);
        check_eq("drain_queue", exp_q.size(), 0);
        tick();
    endtask

    task automatic rand_cmd();
        bus.cmd_a   = 8'($urandom);
        bus.cmd_b   = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
        bus.cmd_op  = 3'($urandom_range(0, 7));
        bus.cmd_tag = 4'($urandom);
    endtask

    initial begin
        int lat;
        int s0;
        int r0;
        int idx;
        logic acc;
        logic [7:0] cap_a [6];
        logic [7:0] cap_b [6];

        reset_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_a = '0;
        bus.cmd_b = '0;
        bus.cmd_op = '0;
        bus.cmd_tag = '0;
        bus.rsp_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_eq("rst_cmd_ready", bus.cmd_ready, 0);
        check_eq("rst_ctl", {bus.alu_start, bus.rsp_valid, bus.rsp_err, bus.busy}, 0);
        check_eq("rst_alu", {bus.alu_a, bus.alu_b, bus.alu_mode}, 0);
        check_eq("rst_rsp", {bus.rsp_data, bus.rsp_tag}, 0);
        tick();
        reset_n = 1'b1;
        @(negedge clock);
        check_eq("post_rst_ready", bus.cmd_ready, 1);
        check_eq("post_rst_busy", bus.busy, 0);
        tick();

        // ADD with wrap, nominal latency
        s0 = n_starts;
        send_cmd(8'd200, 8'd100, 3'd0, 4'd3);
        wait_rsp(lat);
        check_eq("add_lat", lat, RL + 3);
        check_eq("add_data", bus.rsp_data, 44);
        check_eq("add_tag", bus.rsp_tag, 3);
        check_eq("add_err", bus.rsp_err, 0);
        tick();
        wait_idle();
        check_eq("add_starts", n_starts - s0, 1);

        // Error path: zero divisor and illegal opcode
        s0 = n_starts;
        send_cmd(8'd7, 8'd0, 3'd3, 4'd1);
        wait_rsp(lat);
        check_eq("div0_lat", lat, 2);
        check_eq("div0_data", bus.rsp_data, 0);
        check_eq("div0_tag", bus.rsp_tag, 1);
        check_eq("div0_err", bus.rsp_err, 1);
        tick();
        send_cmd(8'd9, 8'd2, 3'd6, 4'd2);
        wait_rsp(lat);
        check_eq("ill_lat", lat, 2);
        check_eq("ill_data", bus.rsp_data, 0);
        check_eq("ill_tag", bus.rsp_tag, 2);
        check_eq("ill_err", bus.rsp_err, 1);
        tick();
        wait_idle();
        check_eq("err_starts", n_starts - s0, 0);

        // Back-to-back MUL then MOD
        send_cmd(8'd16, 8'd16, 3'd2, 4'd4);
        send_cmd(8'd23, 8'd5, 3'd4, 4'd5);
        wait_rsp(lat);
        check_eq("mul_data", bus.rsp_data, 0);
        check_eq("mul_tag", bus.rsp_tag, 4);
        check_eq("mul_err", bus.rsp_err, 0);
        tick();
        wait_rsp(lat);
        check_eq("mod_data", bus.rsp_data, 3);
        check_eq("mod_tag", bus.rsp_tag, 5);
        check_eq("mod_err", bus.rsp_err, 0);
        tick();
        wait_idle();

        // Capacity: FIFO_DEPTH queued plus one working
        r0 = n_rsp;
        for (int i = 0; i < 6; i++) begin
            cap_a[i] = 8'($urandom);
            cap_b[i] = 8'($urandom);
        end
        bus.rsp_ready = 1'b0;
        idx = 0;
        bus.cmd_a = cap_a[0];
        bus.cmd_b = cap_b[0];
        bus.cmd_op = 3'd0;
        bus.cmd_tag = 4'd6;
        bus.cmd_valid = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clock);
            acc = bus.cmd_ready;
            tick();
            if (acc) begin
                idx++;
                if (idx < 6) begin
                    bus.cmd_a = cap_a[idx];
                    bus.cmd_b = cap_b[idx];
                    bus.cmd_tag = 4'(6 + idx);
                end else begin
                    bus.cmd_valid = 1'b0;
                end
            end
        end
        check_eq("cap_accepted", idx, FD + 1);
        @(negedge clock);
        check_eq("cap_full_ready", bus.cmd_ready, 0);
        tick();
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 60 && idx < 6; c++) begin
            @(negedge clock);
            acc = bus.cmd_ready;
            tick();
            if (acc) begin
                idx++;
                bus.cmd_valid = 1'b0;
            end
        end
        check_eq("cap_sixth", idx, 6);
        wait_idle();
        check_eq("cap_rsps", n_rsp - r0, 6);

        // Reset during ISSUE with two commands queued
        bus.rsp_ready = 1'b0;
        send_cmd(8'd1, 8'd2, 3'd0, 4'd12);
        wait_rsp(lat);
        tick();
        send_cmd(8'd3, 8'd4, 3'd2, 4'd13);
        send_cmd(8'd5, 8'd6, 3'd1, 4'd14);
        send_cmd(8'd8, 8'd3, 3'd3, 4'd15);
        bus.rsp_ready = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clock);
            acc = bus.alu_start;
            if (!acc) tick();
        end
        check_eq("rst_mid_issue", acc, 1);
        check_eq("rst_mid_queue", exp_q.size(), 3);
        #1;
        reset_n = 1'b0;
        @(negedge clock);
        check_eq("mid_rst_cmd_ready", bus.cmd_ready, 0);
        check_eq("mid_rst_ctl", {bus.alu_start, bus.rsp_valid, bus.rsp_err, bus.busy}, 0);
        check_eq("mid_rst_alu", {bus.alu_a, bus.alu_b, bus.alu_mode}, 0);
        check_eq("mid_rst_rsp", {bus.rsp_data, bus.rsp_tag}, 0);
        tick();
        tick();
        reset_n = 1'b1;
        @(negedge clock);
        check_eq("rel_busy", bus.busy, 0);
        check_eq("rel_ready", bus.cmd_ready, 1);
        tick();
        repeat (20) tick();
        check_eq("no_stale_rsp", n_unexp, 0);

        // Random traffic, random then pulsed back-pressure
        bus.cmd_valid = 1'b0;
        rand_cmd();
        for (int c = 0; c < 600; c++) begin
            @(negedge clock);
            acc = bus.cmd_valid && bus.cmd_ready;
            tick();
            if (acc || !bus.cmd_valid) begin
                bus.cmd_valid = ($urandom_range(0, 9) < 6);
                rand_cmd();
            end
            if (c < 400) bus.rsp_ready = 1'($urandom_range(0, 1));
            else         bus.rsp_ready = ~bus.rsp_ready;
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        wait_idle();
        check_eq("final_unexpected", n_unexp, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
